// File: rtl/serial_word_deserializer.sv
// Rebuilds WIDTH-bit words from an MSB-first serial stream framed by a start strobe,
// and holds each finished word in a one-deep valid/ready output buffer.
module serial_word_deserializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;

    logic [CNT_W-1:0] cnt_base_s;
    logic [WIDTH-1:0] shreg_base_s;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shreg_d;
    logic             capture_s;
    logic             done_s;

    // Capture/completion decode; a start strobe rebases the frame before the bit lands
    always_comb begin
        cnt_base_s   = cnt_q;
        shreg_base_s = shreg_q;
        if (start) begin
            cnt_base_s   = '0;
            shreg_base_s = '0;
        end else begin
            cnt_base_s   = cnt_q;
            shreg_base_s = shreg_q;
        end
        capture_s = bit_en && (start || (state_q == COLLECT));
        shreg_d   = {shreg_base_s[WIDTH-2:0], ser_in};
        cnt_d     = cnt_base_s + CNT_W'(1);
        done_s    = capture_s && (cnt_base_s == LAST_IDX);
    end

    // Frame FSM, bit counter, shifter and output buffer with overrun tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (done_s) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (capture_s) begin
                state_q <= COLLECT;
                cnt_q   <= cnt_d;
                shreg_q <= shreg_d;
            end else if (start) begin
                state_q <= COLLECT;
                cnt_q   <= '0;
                shreg_q <= '0;
            end else begin
                state_q <= state_q;
                cnt_q   <= cnt_q;
                shreg_q <= shreg_q;
            end

            // A word finishing into a stalled full buffer is dropped, not merged
            if (done_s) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q  <= shreg_d;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == COLLECT);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: directed scenarios plus a randomized run
// checked against a queue-based frame model.
module tb_serial_word_deserializer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        bit_en;
    logic        ser_in;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int tests_run;
    int fail_cnt;

    // Reference model state
    bit          m_bits[$];
    bit          m_collect;
    logic [31:0] m_data;
    bit          m_valid;
    bit          m_ovr;

    serial_word_deserializer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_en    (bit_en),
        .ser_in    (ser_in),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_bits.delete();
        m_collect = 1'b0;
        m_data    = 32'h0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
    endtask

    // One clock edge of the frame model: collect bits in a list, pack when 32 arrive
    task automatic model_edge(input logic s, input logic be, input logic si, input logic rdy);
        logic [31:0] w;
        bit          done;
        done = 1'b0;
        w    = 32'h0;
        if (s) begin
            m_bits.delete();
            m_collect = 1'b1;
        end
        if (be && m_collect) begin
            m_bits.push_back(si);
            if (m_bits.size() == 32) begin
                foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
                done = 1'b1;
                m_bits.delete();
                m_collect = 1'b0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic s, input logic be, input logic si, input logic rdy);
        start     = s;
        bit_en    = be;
        ser_in    = si;
        out_ready = rdy;
        @(posedge clk);
        model_edge(s, be, si, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        bit_en = 1'b0;
        ser_in = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #2;
        reset = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic rdy, input logic rdy_last);
        for (int i = 0; i < 32; i++)
            step(i == 0, 1'b1, w[31-i], (i == 31) ? rdy_last : rdy);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_flags: valid=%b busy=%b overrun=%b expected 0 0 0", out_valid, busy, overrun);
        end
        tests_run++;
        if (out_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_data: got %h expected 00000000", out_data);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [31:0] w;
        int early;
        w = 32'hDEADBEEF;
        early = 0;
        do_reset();
        for (int i = 0; i < 31; i++) begin
            step(i == 0, 1'b1, w[31-i], 1'b1);
            if (out_valid !== 1'b0 || busy !== 1'b1) early++;
        end
        tests_run++;
        if (early != 0) begin
            fail_cnt++;
            $display("FAIL basic_inframe: %0d bad cycles (valid/busy) expected 0", early);
        end
        step(1'b0, 1'b1, w[0], 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL basic_word: valid=%b data=%h busy=%b expected 1 deadbeef 0", out_valid, out_data, busy);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL basic_pulse: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w;
        int bad;
        w = 32'hDEADBEEF;
        bad = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(i == 0, 1'b1, w[31-i], 1'b1);
            if (i < 31) begin
                if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
                step(1'b0, 1'b0, 1'($urandom), 1'b1);
                if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            fail_cnt++;
            $display("FAIL gaps_busy: %0d bad cycles expected 0", bad);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL gaps_word: valid=%b data=%h busy=%b expected 1 deadbeef 0", out_valid, out_data, busy);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL gaps_pulse: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(32'h12345678, 1'b0, 1'b0);
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h12345678 || overrun !== 1'b1) begin
            fail_cnt++;
            $display("FAIL bp_hold: valid=%b data=%h overrun=%b expected 1 12345678 1", out_valid, out_data, overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            fail_cnt++;
            $display("FAIL bp_drain: valid=%b overrun=%b expected 0 1", out_valid, overrun);
        end
    endtask

    task automatic test_no_bubble();
        do_reset();
        send_word(32'h00000001, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000001) begin
            fail_cnt++;
            $display("FAIL nb_first: valid=%b data=%h expected 1 00000001", out_valid, out_data);
        end
        send_word(32'hFFFFFFFF, 1'b0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || overrun !== 1'b0) begin
            fail_cnt++;
            $display("FAIL nb_replace: valid=%b data=%h overrun=%b expected 1 ffffffff 0", out_valid, out_data, overrun);
        end
    endtask

    task automatic test_restart();
        logic [31:0] w;
        int pulses;
        w = 32'hA5A5A5A5;
        pulses = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (out_valid) pulses++;
        end
        for (int i = 0; i < 32; i++) begin
            step(i == 0, 1'b1, w[31-i], 1'b1);
            if (out_valid) pulses++;
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
            fail_cnt++;
            $display("FAIL restart_word: valid=%b data=%h expected 1 a5a5a5a5", out_valid, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (out_valid) pulses++;
        end
        tests_run++;
        if (pulses != 1 || overrun !== 1'b0) begin
            fail_cnt++;
            $display("FAIL restart_pulses: pulses=%0d overrun=%b expected 1 0", pulses, overrun);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w;
        do_reset();
        send_word(32'h55AA33CC, 1'b0, 1'b0);
        w = 32'h76543210;
        for (int i = 0; i < 20; i++) step(i == 0, 1'b1, w[31-i], 1'b0);
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL midrst_pre: busy=%b valid=%b expected 1 1", busy, out_valid);
        end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL midrst_async: busy=%b valid=%b data=%h expected 0 0 00000000", busy, out_valid, out_data);
        end
        #1;
        reset = 1'b1;
        send_word(32'h0F0F0F0F, 1'b1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h0F0F0F0F || overrun !== 1'b0) begin
            fail_cnt++;
            $display("FAIL midrst_after: valid=%b data=%h overrun=%b expected 1 0f0f0f0f 0", out_valid, out_data, overrun);
        end
    endtask

    task automatic test_random();
        logic s, be, si, rdy;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 800 == 799) do_reset();
            s   = ($urandom_range(0, 59) == 0);
            be  = ($urandom_range(0, 3) != 0);
            si  = 1'($urandom);
            rdy = ($urandom_range(0, 4) != 0);
            step(s, be, si, rdy);
            tests_run++;
            if (out_valid !== m_valid || busy !== m_collect || overrun !== m_ovr ||
                (m_valid && out_data !== m_data)) begin
                fail_cnt++;
                $display("FAIL random_c%0d: valid=%b busy=%b ovr=%b data=%h expected %b %b %b %h",
                         c, out_valid, busy, overrun, out_data, m_valid, m_collect, m_ovr, m_data);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        bit_en    = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #12;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_no_bubble();
        test_restart();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
